// File: rtl/rf_wport_if.sv
// Bus bundle between the pipeline/long-unit side and the register-file write-port arbiter.
interface rf_wport_if;
    // wb_*: the pipeline presents wb_valid; a request is taken in any cycle hold_pipe is low,
    //   otherwise wb_* must stay stable. lu_*: a result transfers when lu_valid && lu_ready.
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        hold_pipe;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        lu_issue;
    logic [4:0]  lu_issue_rd;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [31:0] pending;

    modport master (
        output wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data, lu_issue, lu_issue_rd,
        input  hold_pipe, lu_ready, rf_we, rf_wa, rf_wd, pending
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data, lu_issue, lu_issue_rd,
        output hold_pipe, lu_ready, rf_we, rf_wa, rf_wd, pending
    );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: pipeline writeback first, long-unit results queued in a
// FIFO with a starvation hold, plus a pending-destination scoreboard for hazard detection.
module rf_wport_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input logic        clk_i,
    input logic        rst_ni,
    rf_wport_if.slave  bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [WW-1:0] WAIT_MAX_C = WW'(MAX_WAIT);
    localparam logic [WW-1:0] WAIT_TRIG  = WW'(MAX_WAIT - 1);

    logic [4:0]    rd_mem_q   [FIFO_DEPTH];
    logic [31:0]   data_mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          hold_q, hold_d;
    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_wa_q, rf_wa_d;
    logic [31:0]   rf_wd_q, rf_wd_d;
    logic [31:0]   pending_q, pending_d;

    logic          fifo_ne;
    logic          lu_ready;
    logic          enq;
    logic          deq;
    logic          pipe_wr;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;
    logic [31:0]   set_vec;
    logic [31:0]   clr_vec;

    assign fifo_ne   = (count_q != '0);
    assign lu_ready  = (count_q < DEPTH_C);
    assign head_rd   = rd_mem_q[rd_ptr_q];
    assign head_data = data_mem_q[rd_ptr_q];
    // rd==0 results complete the handshake but never occupy an entry.
    assign enq       = bus.lu_valid && lu_ready && (bus.lu_rd != 5'd0);

    always_comb begin
        deq     = 1'b0;
        pipe_wr = 1'b0;
        if (hold_q && fifo_ne) begin
            deq = 1'b1;
        end else if (bus.wb_valid && !hold_q && (bus.wb_rd != 5'd0)) begin
            pipe_wr = 1'b1;
        end else if (fifo_ne) begin
            deq = 1'b1;
        end
    end

    always_comb begin
        rf_we_d = 1'b0;
        rf_wa_d = rf_wa_q;
        rf_wd_d = rf_wd_q;
        if (deq) begin
            rf_we_d = 1'b1;
            rf_wa_d = head_rd;
            rf_wd_d = head_data;
        end else if (pipe_wr) begin
            rf_we_d = 1'b1;
            rf_wa_d = bus.wb_rd;
            rf_wd_d = bus.wb_data;
        end
    end

    always_comb begin
        wr_ptr_d = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(enq) - CW'(deq);
    end

    // Starvation guard: the hold fires once, the cycle after the wait reaches MAX_WAIT-1,
    // and that held cycle always dequeues, which clears the counter again.
    always_comb begin
        wait_d = wait_q;
        hold_d = 1'b0;
        if (!fifo_ne || deq) begin
            wait_d = '0;
        end else begin
            wait_d = (wait_q == WAIT_MAX_C) ? wait_q : wait_q + WW'(1);
            hold_d = (wait_q == WAIT_TRIG);
        end
    end

    always_comb begin
        set_vec   = (bus.lu_issue && (bus.lu_issue_rd != 5'd0)) ? (32'd1 << bus.lu_issue_rd) : 32'd0;
        clr_vec   = deq ? (32'd1 << head_rd) : 32'd0;
        pending_d = ((pending_q & ~clr_vec) | set_vec) & ~32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wait_q    <= '0;
            hold_q    <= 1'b0;
            rf_we_q   <= 1'b0;
            rf_wa_q   <= 5'd0;
            rf_wd_q   <= 32'd0;
            pending_q <= 32'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wait_q    <= wait_d;
            hold_q    <= hold_d;
            rf_we_q   <= rf_we_d;
            rf_wa_q   <= rf_wa_d;
            rf_wd_q   <= rf_wd_d;
            pending_q <= pending_d;
        end
    end

    // Storage is not reset; validity is carried entirely by count_q.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            rd_mem_q[wr_ptr_q]   <= bus.lu_rd;
            data_mem_q[wr_ptr_q] <= bus.lu_data;
        end
    end

    assign bus.lu_ready  = lu_ready;
    assign bus.hold_pipe = hold_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_wa     = rf_wa_q;
    assign bus.rf_wd     = rf_wd_q;
    assign bus.pending   = pending_q;
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Bench for rf_wport_arbiter: directed scenarios then random traffic, all checked against
// a queue-based reference model of the write-port sharing rules.
module tb_rf_wport_arbiter;
    localparam int DEPTH = 2;
    localparam int MAXW  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_wport_if bus();

    rf_wport_arbiter #(.FIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queued long-unit results as {rd, data}, plus the visible outputs.
    logic [36:0] exp_q[$];
    logic [31:0] m_pend;
    int          m_wait;
    bit          m_hold;
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pend = 32'd0;
        m_wait = 0;
        m_hold = 1'b0;
        m_we   = 1'b0;
        m_wa   = 5'd0;
        m_wd   = 32'd0;
    endtask

    task automatic idle_inputs();
        bus.wb_valid    = 1'b0;
        bus.wb_rd       = 5'd0;
        bus.wb_data     = 32'd0;
        bus.lu_valid    = 1'b0;
        bus.lu_rd       = 5'd0;
        bus.lu_data     = 32'd0;
        bus.lu_issue    = 1'b0;
        bus.lu_issue_rd = 5'd0;
    endtask

    task automatic check_outputs();
        check("hold_pipe", {31'd0, bus.hold_pipe}, {31'd0, m_hold});
        check("lu_ready",  {31'd0, bus.lu_ready},  (exp_q.size() < DEPTH) ? 32'd1 : 32'd0);
        check("rf_we",     {31'd0, bus.rf_we},     {31'd0, m_we});
        check("rf_wa",     {27'd0, bus.rf_wa},     {27'd0, m_wa});
        check("rf_wd",     bus.rf_wd,              m_wd);
        check("pending",   bus.pending,            m_pend);
    endtask

    // Check at the falling edge, advance the model with this cycle's inputs, end at posedge+1.
    task automatic step();
        bit ne, rdy, deq, pipe, new_hold;
        logic [36:0] head;
        @(negedge clk);
        check_outputs();
        ne   = (exp_q.size() != 0);
        rdy  = (exp_q.size() < DEPTH);
        deq  = 1'b0;
        pipe = 1'b0;
        if (m_hold && ne) deq = 1'b1;
        else if (bus.wb_valid && !m_hold && bus.wb_rd != 5'd0) pipe = 1'b1;
        else if (ne) deq = 1'b1;
        new_hold = ne && !deq && (m_wait == MAXW - 1);
        if (!ne || deq) m_wait = 0;
        else if (m_wait < MAXW) m_wait = m_wait + 1;
        m_hold = new_hold;
        m_we = 1'b0;
        if (deq) begin
            head = exp_q.pop_front();
            m_we = 1'b1;
            m_wa = head[36:32];
            m_wd = head[31:0];
            m_pend[head[36:32]] = 1'b0;
        end else if (pipe) begin
            m_we = 1'b1;
            m_wa = bus.wb_rd;
            m_wd = bus.wb_data;
        end
        if (bus.lu_issue && bus.lu_issue_rd != 5'd0) m_pend[bus.lu_issue_rd] = 1'b1;
        if (bus.lu_valid && rdy && bus.lu_rd != 5'd0) exp_q.push_back({bus.lu_rd, bus.lu_data});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        bit acc;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset.
        repeat (4) step();

        // Issue r5, later its result arrives and drains.
        bus.lu_issue = 1'b1; bus.lu_issue_rd = 5'd5;
        step();
        idle_inputs();
        repeat (2) step();
        bus.lu_valid = 1'b1; bus.lu_rd = 5'd5; bus.lu_data = 32'hDEADBEEF;
        step();
        idle_inputs();
        repeat (3) step();

        // Pipeline streams r3 while r7 waits: starvation hold lets r7 through.
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h11;
        bus.lu_valid = 1'b1; bus.lu_rd = 5'd7; bus.lu_data = 32'h77;
        step();
        bus.lu_valid = 1'b0;
        repeat (10) step();

        // Three back-to-back results into a two-entry FIFO.
        bus.wb_rd = 5'd4; bus.wb_data = 32'h44;
        sent = 0;
        for (int c = 0; c < 40 && sent < 3; c++) begin
            bus.lu_valid = 1'b1;
            bus.lu_rd    = 5'(10 + sent);
            bus.lu_data  = 32'hA0 + 32'(sent);
            acc = (exp_q.size() < DEPTH);
            step();
            if (acc) sent++;
        end
        idle_inputs();
        repeat (4) step();

        // Zero destinations on both sides, then a zero-rd pipeline slot freeing the port.
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'h55;
        bus.lu_valid = 1'b1; bus.lu_rd = 5'd0; bus.lu_data = 32'h66;
        step();
        bus.wb_rd = 5'd3; bus.lu_rd = 5'd8; bus.lu_data = 32'h88;
        step();
        bus.lu_valid = 1'b0; bus.wb_rd = 5'd0;
        repeat (2) step();
        idle_inputs();
        repeat (2) step();

        // Reissue of r9 on the cycle its older result drains keeps PENDING[9] set.
        bus.lu_issue = 1'b1; bus.lu_issue_rd = 5'd9;
        step();
        idle_inputs();
        bus.lu_valid = 1'b1; bus.lu_rd = 5'd9; bus.lu_data = 32'h99;
        step();
        idle_inputs();
        bus.lu_issue = 1'b1; bus.lu_issue_rd = 5'd9;
        step();
        idle_inputs();
        check("pend9_sticky", {31'd0, bus.pending[9]}, 32'd1);
        repeat (2) step();

        // Reset while two entries are queued.
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h33;
        bus.lu_valid = 1'b1; bus.lu_rd = 5'd20; bus.lu_data = 32'h2020;
        step();
        bus.lu_rd = 5'd21; bus.lu_data = 32'h2121;
        step();
        bus.lu_valid = 1'b0;
        step();
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) step();

        // Random traffic; pipeline holds its request while HOLD_PIPE is up.
        for (int c = 0; c < 600; c++) begin
            if (!m_hold) begin
                bus.wb_valid = ($urandom_range(0, 99) < 60);
                bus.wb_rd    = 5'($urandom_range(0, 31));
                bus.wb_data  = $urandom;
            end
            if (!(bus.lu_valid && exp_q.size() >= DEPTH)) begin
                bus.lu_valid = ($urandom_range(0, 99) < 45);
                bus.lu_rd    = 5'($urandom_range(0, 31));
                bus.lu_data  = $urandom;
            end
            bus.lu_issue    = ($urandom_range(0, 99) < 30);
            bus.lu_issue_rd = 5'($urandom_range(0, 31));
            step();
        end
        idle_inputs();
        repeat (8) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback path and a long-latency unit (multi-cycle divider or memory refill) that completes out of order.
- Pipeline writeback has default priority. Long-unit results queue in a small FIFO.
- A starvation counter forces a one-cycle pipeline hold so queued results always drain.
- A 32-bit pending scoreboard tracks destination registers owned by in-flight long-unit operations, for the hazard logic.

Parameters:
- FIFO_DEPTH, 2, number of long-unit result entries; power of two, at least 2.
- MAX_WAIT, 4, cycles a non-empty FIFO may go without dequeuing before HOLD_PIPE is forced; at least 1.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- WB_VALID  in  1  pipeline writeback request.
- WB_RD  in  5  pipeline destination register.
- WB_DATA  in  32  pipeline writeback value.
- HOLD_PIPE  out  1  registered; pipeline writeback not accepted this cycle, pipeline must hold WB_* stable.
- LU_VALID  in  1  long-unit result valid.
- LU_RD  in  5  long-unit destination register.
- LU_DATA  in  32  long-unit result.
- LU_READY  out  1  FIFO can accept a result.
- LU_ISSUE  in  1  long-unit operation issued this cycle.
- LU_ISSUE_RD  in  5  destination of the issued operation.
- RF_WE  out  1  registered write enable to register file.
- RF_WA  out  5  registered write address.
- RF_WD  out  32  registered write data.
- PENDING  out  32  scoreboard; bit n set means rn awaits a long-unit result; bit 0 is always 0.

Behaviour:
- Reset (async, RST_N low): RF_WE=0, RF_WA=0, RF_WD=0, HOLD_PIPE=0, PENDING=0, FIFO empty, wait counter=0, LU_READY=1 once reset is released.
- Reset mid-operation discards FIFO contents and the scoreboard with no RF write. Upstream units are flushed by the same reset.
- LU_READY = (count < FIFO_DEPTH), combinational from registered count only. There is no same-cycle bypass, so a full FIFO stays not-ready even during a dequeue.
- Enqueue: LU_VALID && LU_READY. If LU_RD==0 the result is accepted and discarded, with no entry written.
- Pipeline accept: WB_VALID && !HOLD_PIPE. An accepted request with WB_RD==0 consumes the slot without writing.
- Grant, evaluated each cycle; one RF write at most:
  - If HOLD_PIPE=1 and FIFO is non-empty: dequeue the FIFO head.
  - Else if the pipeline request is accepted with rd!=0: pipeline write.
  - Else if FIFO is non-empty: dequeue the head.
  - Else: no write.
- Write latency: the granted request appears on RF_WE/RF_WA/RF_WD the following cycle (1-cycle latency). RF_WE=0 when nothing is granted; RF_WA and RF_WD hold their previous values.
- Wait counter:
  - Cleared when FIFO is empty or a dequeue occurs.
  - Otherwise increments, saturating at MAX_WAIT.
  - HOLD_PIPE is registered as 1 in the cycle after the counter reaches MAX_WAIT−1 with no dequeue. It lasts exactly one cycle, then returns to 0.
- Scoreboard:
  - LU_ISSUE with rd!=0 sets PENDING[rd].
  - A dequeue-granted FIFO write clears PENDING[rd] on the same edge the write is registered.
  - Set and clear of the same rd in the same cycle: set wins.
  - Pipeline writes never modify PENDING.
- FIFO pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH. Simultaneous enqueue and dequeue leaves count unchanged.
- Ordering: FIFO entries are written in arrival order. A pipeline write and a FIFO write never occur in the same cycle.

Test Plan:
- Reset then idle -> RF_WE=0, PENDING=0, LU_READY=1, HOLD_PIPE=0 every cycle.
- LU_ISSUE rd=5; later LU_VALID rd=5 data=0xDEADBEEF with WB_VALID low -> PENDING[5]=1 until RF_WE=1 RF_WA=5 RF_WD=0xDEADBEEF, one cycle after dequeue; PENDING[5]=0 after.
- WB_VALID held high (rd=3, data=0x11) with one queued LU result rd=7, MAX_WAIT=4 -> four pipeline writes of r3, then HOLD_PIPE=1 for one cycle, then a write of r7, then the held r3 write resumes.
- Three back-to-back LU_VALID results with WB_VALID high, FIFO_DEPTH=2 -> LU_READY=0 after two enqueues; the third is accepted only after a dequeue; writes emerge in arrival order.
- WB_RD=0 and LU_RD=0 requests -> no RF_WE pulse for either. The zero-rd pipeline slot lets a queued FIFO head write that cycle.
- LU_ISSUE rd=9 coinciding with dequeue of an older rd=9 result -> write of r9 occurs and PENDING[9] remains 1. Asserting RST_N low with 2 queued entries -> queue emptied immediately, with no further RF_WE.
